// File: rtl/gate_response_checker.sv
// gate_response_checker: checks 2-input gate responses per lane, counting vectors, errors and truth-table coverage.
// Defining GATE_CHK_FIRST_FAIL_EN adds capture ports for the first mismatching sample of a run.
module gate_response_checker #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             cfg_err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
`ifdef GATE_CHK_FIRST_FAIL_EN
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_y,
    output logic [CNT_W-1:0] fail_idx,
    output logic             fail_vld,
`endif
    output logic             cov_full
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [2:0]         gate_q, gate_d;
    logic               cfg_err_q, cfg_err_d, pass_q, pass_d, cov_full_q, cov_full_d;
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
    logic [4*WIDTH-1:0] cov_q, cov_d, hit;
    logic [WIDTH-1:0]   exp_y;
    logic               accept, mismatch, launch;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [WIDTH-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_y_q, fail_y_d;
    logic [CNT_W-1:0]   fail_idx_q, fail_idx_d;
    logic               fail_vld_q, fail_vld_d;
`endif

    assign in_ready = state_q == RUN;
    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign pass     = pass_q;
    assign cfg_err  = cfg_err_q;
    assign vec_cnt  = vec_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign cov_full = cov_full_q;
    assign accept   = in_valid && in_ready;
    assign launch   = start && state_q != RUN;
    assign exp_y    = gate_q == 3'd0 ? ~(a & b) :
                      gate_q == 3'd1 ? a & b :
                      gate_q == 3'd2 ? a | b :
                      gate_q == 3'd3 ? ~(a | b) :
                      gate_q == 3'd4 ? a ^ b :
                      gate_q == 3'd5 ? ~(a ^ b) : '0;
    assign mismatch = |(y ^ exp_y);

    // One-hot coverage slot per lane, indexed by the {a,b} combination seen.
    for (genvar i = 0; i < WIDTH; i++) begin : g_hit
        assign hit[4*i +: 4] = 4'b0001 << {a[i], b[i]};
    end

`ifdef GATE_CHK_FIRST_FAIL_EN
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_y   = fail_y_q;
    assign fail_idx = fail_idx_q;
    assign fail_vld = fail_vld_q;
`endif

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        cfg_err_d  = cfg_err_q;
        pass_d     = pass_q;
        cov_full_d = cov_full_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        cov_d      = cov_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_y_d   = fail_y_q;
        fail_idx_d = fail_idx_q;
        fail_vld_d = fail_vld_q;
`endif
        if (launch) begin
            gate_d     = gate_sel;
            cfg_err_d  = gate_sel > 3'd5;
            pass_d     = 1'b0;
            cov_full_d = 1'b0;
            vec_cnt_d  = '0;
            err_cnt_d  = '0;
            cov_d      = '0;
            state_d    = gate_sel > 3'd5 ? DONE : RUN;
`ifdef GATE_CHK_FIRST_FAIL_EN
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_y_d   = '0;
            fail_idx_d = '0;
            fail_vld_d = 1'b0;
`endif
        end else if (state_q == RUN) begin
            if (accept) begin
                vec_cnt_d  = &vec_cnt_q ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
                err_cnt_d  = mismatch && !(&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
                cov_d      = cov_q | hit;
                cov_full_d = &cov_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
                if (mismatch && !fail_vld_q) begin
                    fail_a_d   = a;
                    fail_b_d   = b;
                    fail_y_d   = y;
                    fail_idx_d = vec_cnt_q;
                    fail_vld_d = 1'b1;
                end
`endif
            end
            // A sample coinciding with the exit is folded into the verdict.
            if (finish || cov_full_q) begin
                state_d = DONE;
                pass_d  = err_cnt_d == '0 && cov_full_d && !cfg_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            cfg_err_q  <= 1'b0;
            pass_q     <= 1'b0;
            cov_full_q <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            cov_q      <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_y_q   <= '0;
            fail_idx_q <= '0;
            fail_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            cfg_err_q  <= cfg_err_d;
            pass_q     <= pass_d;
            cov_full_q <= cov_full_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            cov_q      <= cov_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_y_q   <= fail_y_d;
            fail_idx_q <= fail_idx_d;
            fail_vld_q <= fail_vld_d;
`endif
        end
    end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: two checkers (8-bit and 2-bit counters) share stimulus and are compared every
// cycle against a truth-table reference model; directed runs first, then random traffic.
module tb_gate_response_checker;
    localparam int W = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, finish, in_valid;
    logic [2:0]   gate_sel;
    logic [W-1:0] a, b, y;
    logic         n_rdy, n_busy, n_done, n_pass, n_cfg, n_cov;
    logic         s_rdy, s_busy, s_done, s_pass, s_cfg, s_cov;
    logic [7:0]   n_vec, n_err;
    logic [1:0]   s_vec, s_err;
`ifdef GATE_CHK_FIRST_FAIL_EN
    logic [W-1:0] n_fa, n_fb, n_fy, s_fa, s_fb, s_fy;
    logic [7:0]   n_fidx;
    logic [1:0]   s_fidx;
    logic         n_fvld, s_fvld;
`endif

    gate_response_checker #(.WIDTH(W), .CNT_W(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .finish(finish),
        .in_valid(in_valid), .in_ready(n_rdy), .a(a), .b(b), .y(y), .busy(n_busy), .done(n_done),
        .pass(n_pass), .cfg_err(n_cfg), .vec_cnt(n_vec), .err_cnt(n_err),
`ifdef GATE_CHK_FIRST_FAIL_EN
        .fail_a(n_fa), .fail_b(n_fb), .fail_y(n_fy), .fail_idx(n_fidx), .fail_vld(n_fvld),
`endif
        .cov_full(n_cov)
    );

    gate_response_checker #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .finish(finish),
        .in_valid(in_valid), .in_ready(s_rdy), .a(a), .b(b), .y(y), .busy(s_busy), .done(s_done),
        .pass(s_pass), .cfg_err(s_cfg), .vec_cnt(s_vec), .err_cnt(s_err),
`ifdef GATE_CHK_FIRST_FAIL_EN
        .fail_a(s_fa), .fail_b(s_fb), .fail_y(s_fy), .fail_idx(s_fidx), .fail_vld(s_fvld),
`endif
        .cov_full(s_cov)
    );

    int tests = 0, fails = 0;
    // Truth tables indexed by {a,b}: NAND AND OR NOR XOR XNOR, reserved codes give nothing.
    bit [3:0] tt [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0000, 4'b0000};

    int           m_st, m_vec, m_err, m_fidx;
    bit [2:0]     m_gate;
    bit [3:0]     m_seen [W];
    bit           m_cov, m_cfg, m_pass, m_fvld;
    bit [W-1:0]   m_fa, m_fb, m_fy;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic clear_run();
        m_vec = 0; m_err = 0; m_cov = 0; m_pass = 0;
        m_fvld = 0; m_fa = 0; m_fb = 0; m_fy = 0; m_fidx = 0;
        for (int i = 0; i < W; i++) m_seen[i] = 4'b0;
    endtask

    task automatic model_step();
        bit bad, was_cov;
        if (!rst_n) begin
            clear_run();
            m_st = 0; m_cfg = 0; m_gate = 0;
        end else if (start && m_st != 1) begin
            clear_run();
            m_gate = gate_sel;
            m_cfg  = gate_sel >= 6;
            m_st   = m_cfg ? 2 : 1;
        end else if (m_st == 1) begin
            was_cov = m_cov;
            if (in_valid) begin
                bad = 0;
                for (int i = 0; i < W; i++) begin
                    if (y[i] != tt[m_gate][{a[i], b[i]}]) bad = 1;
                    m_seen[i][{a[i], b[i]}] = 1'b1;
                end
                if (bad && !m_fvld) begin
                    m_fvld = 1; m_fa = a; m_fb = b; m_fy = y; m_fidx = m_vec;
                end
                m_vec++;
                if (bad) m_err++;
                m_cov = 1;
                for (int i = 0; i < W; i++) if (m_seen[i] != 4'hf) m_cov = 0;
            end
            if (finish || was_cov) begin
                m_st   = 2;
                m_pass = m_err == 0 && m_cov && !m_cfg;
            end
        end
    endtask

    task automatic cmp(string p, int mx, logic rdy, logic bsy, logic dn, logic ps, logic ce,
                       logic [7:0] vc, logic [7:0] ec, logic cf);
        check({p, ".rdy"}, rdy, m_st == 1);
        check({p, ".busy"}, bsy, m_st == 1);
        check({p, ".done"}, dn, m_st == 2);
        check({p, ".pass"}, ps, m_pass);
        check({p, ".cfg"}, ce, m_cfg);
        check({p, ".vec"}, vc, sat(m_vec, mx));
        check({p, ".err"}, ec, sat(m_err, mx));
        check({p, ".cov"}, cf, m_cov);
    endtask

    task automatic compare_all();
        cmp("n", 255, n_rdy, n_busy, n_done, n_pass, n_cfg, n_vec, n_err, n_cov);
        cmp("s", 3, s_rdy, s_busy, s_done, s_pass, s_cfg, {6'b0, s_vec}, {6'b0, s_err}, s_cov);
`ifdef GATE_CHK_FIRST_FAIL_EN
        check("n.fvld", n_fvld, m_fvld);
        check("n.fa", n_fa, m_fa);
        check("n.fb", n_fb, m_fb);
        check("n.fy", n_fy, m_fy);
        check("n.fidx", n_fidx, sat(m_fidx, 255));
        check("s.fvld", s_fvld, m_fvld);
        check("s.fy", s_fy, m_fy);
        check("s.fidx", s_fidx, sat(m_fidx, 3));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic run_start(input logic [2:0] g);
        gate_sel = g; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input bit av, input bit bv, input bit yv);
        in_valid = 1'b1; a = {W{av}}; b = {W{bv}}; y = {W{yv}};
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        gate_sel = '0; a = '0; b = '0; y = '0;
        tick(); tick();
        check("rst.vec", n_vec, 0);
        check("rst.done", n_done, 0);
        rst_n = 1'b1;
        tick();

        run_start(3'd0);
        send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
        check("nand.vec", n_vec, 4);
        check("nand.cov", n_cov, 1);
        tick();
        check("nand.done", n_done, 1);
        check("nand.pass", n_pass, 1);
        check("nand.svec", s_vec, 3);

        run_start(3'd0);
        send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 1);
        tick();
        check("bad.err", n_err, 1);
        check("bad.done", n_done, 1);
        check("bad.pass", n_pass, 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
        check("bad.fidx", n_fidx, 3);
        check("bad.fa", n_fa, {W{1'b1}});
        check("bad.fy", n_fy, {W{1'b1}});
        check("bad.fvld", n_fvld, 1);
`endif

        run_start(3'd4);
        send(0, 0, 0); send(1, 1, 0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("xor.done", n_done, 1);
        check("xor.cov", n_cov, 0);
        check("xor.pass", n_pass, 0);
        check("xor.err", n_err, 0);

        run_start(3'd7);
        check("rsv.cfg", n_cfg, 1);
        check("rsv.done", n_done, 1);
        check("rsv.busy", n_busy, 0);
        check("rsv.pass", n_pass, 0);
        check("rsv.vec", n_vec, 0);

        run_start(3'd3);
        send(0, 0, 1); send(0, 1, 0); send(1, 0, 0); send(1, 1, 0); send(0, 0, 1); send(1, 1, 0);
        check("nor.nvec", n_vec, 5);
        check("nor.svec", s_vec, 3);
        check("nor.spass", s_pass, 1);
        check("nor.npass", n_pass, 1);

        run_start(3'd0);
        send(0, 0, 1); send(0, 1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid.vec", n_vec, 0);
        check("mid.busy", n_busy, 0);
        check("mid.rdy", n_rdy, 0);
        run_start(3'd0);
        send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
        tick();
        check("mid.pass", n_pass, 1);

        for (int c = 0; c < 1500; c++) begin
            rst_n    = $urandom_range(299) != 0;
            start    = $urandom_range(15) == 0;
            gate_sel = 3'($urandom_range(7));
            finish   = $urandom_range(24) == 0;
            in_valid = $urandom_range(3) != 0;
            a        = W'($urandom);
            b        = W'($urandom);
            for (int i = 0; i < W; i++) y[i] = tt[m_gate][{a[i], b[i]}];
            if ($urandom_range(9) == 0) y = y ^ W'($urandom);
            tick();
        end
        rst_n = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
